// File: rtl/pio_ctrl_pkg.sv
// Shared constants and types for the debounced PIO controller: register map,
// debounce FSM states and the prescaler's minimum period.
package pio_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_EDGE   = 2'd3;

    localparam int MIN_PERIOD = 3;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_EVAL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/pio_sample_tick.sv
// Sample-rate prescaler: one-cycle tick every max(period, MIN_PERIOD) clocks,
// restarted from zero whenever a new period is loaded.
module pio_sample_tick
    import pio_ctrl_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_load,
    output logic                o_tick
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    logic [PERIOD_W-1:0] r_count;
    logic [PERIOD_W-1:0] w_last;

    // The clamp keeps ticks at least three cycles apart so the debounce FSM
    // is always back in S_WAIT before the next one.
    assign w_last = ((i_period < MIN_P) ? MIN_P : i_period) - PERIOD_W'(1);
    assign o_tick = (r_count == w_last);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load || (r_count >= w_last)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/pio_debounce_ctrl.sv
// Debounced switch/button PIO: synchronise, sample, debounce the whole word,
// capture per-bit edges and expose everything on a 4-word Avalon-MM slave.
module pio_debounce_ctrl
    import pio_ctrl_pkg::*;
#(
    parameter int WIDTH          = 18,
    parameter int PERIOD_W       = 16,
    parameter int DEFAULT_PERIOD = 50000,
    parameter int STABLE_COUNT   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [3:0] STAB_MAX = 4'(STABLE_COUNT - 1);
    localparam logic [3:0] STAB_ARM = 4'(STABLE_COUNT - 2);

    logic [WIDTH-1:0]    r_sync1, r_sync_q, r_sample, r_cand, r_data, r_edge, r_mask;
    logic [PERIOD_W-1:0] r_period;
    logic [3:0]          r_stab;
    logic [31:0]         r_readdata;
    logic                r_irq;
    state_t              r_state, w_next_state;

    logic w_wr, w_wr_mask, w_wr_period, w_wr_edge;
    logic w_tick, w_latch, w_eval, w_commit, w_match, w_go_commit;
    logic [WIDTH-1:0] w_edge_next, w_mask_next;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    assign w_wr        = chipselect && !write_n;
    assign w_wr_mask   = w_wr && (address == ADDR_MASK);
    assign w_wr_period = w_wr && (address == ADDR_PERIOD);
    assign w_wr_edge   = w_wr && (address == ADDR_EDGE);
    assign w_unused_wdata = ^writedata;

    pio_sample_tick #(.PERIOD_W(PERIOD_W)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .i_period (r_period),
        .i_load   (w_wr_period),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync_q <= '0;
        end else begin
            r_sync1  <= in_port;
            r_sync_q <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_WAIT;
        else       r_state <= w_next_state;
    end

    assign w_match     = (r_sample == r_cand);
    assign w_go_commit = w_match && (r_stab == STAB_ARM) && (r_cand != r_data);

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT:   if (w_tick) w_next_state = S_EVAL;
            S_EVAL:   w_next_state = w_go_commit ? S_COMMIT : S_WAIT;
            S_COMMIT: w_next_state = S_WAIT;
            default:  w_next_state = S_WAIT;
        endcase
    end

    always_comb begin
        w_latch  = 1'b0;
        w_eval   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_WAIT:   w_latch  = w_tick;
            S_EVAL:   w_eval   = 1'b1;
            S_COMMIT: w_commit = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= '0;
            r_cand   <= '0;
            r_stab   <= '0;
            r_data   <= '0;
        end else begin
            if (w_latch) r_sample <= r_sync_q;
            if (w_eval && !w_go_commit) begin
                if (!w_match) begin
                    r_cand <= r_sample;
                    r_stab <= '0;
                end else if (r_stab != STAB_MAX) begin
                    r_stab <= r_stab + 4'd1;
                end
            end
            if (w_commit) begin
                r_data <= r_cand;
                r_stab <= STAB_MAX;
            end
        end
    end

    // A commit setting an edge bit wins over a W1C clearing it in the same cycle.
    assign w_edge_next = (r_edge & ~(w_wr_edge ? writedata[WIDTH-1:0] : '0))
                       | (w_commit ? (r_data ^ r_cand) : '0);
    assign w_mask_next = w_wr_mask ? writedata[WIDTH-1:0] : r_mask;

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:   w_rdata = 32'(r_data);
            ADDR_MASK:   w_rdata = 32'(r_mask);
            ADDR_PERIOD: w_rdata = 32'(r_period);
            ADDR_EDGE:   w_rdata = 32'(r_edge);
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge     <= '0;
            r_mask     <= '0;
            r_period   <= PERIOD_W'(DEFAULT_PERIOD);
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_edge     <= w_edge_next;
            r_mask     <= w_mask_next;
            r_irq      <= |(w_edge_next & w_mask_next);
            r_readdata <= w_rdata;
            if (w_wr_period) r_period <= writedata[PERIOD_W-1:0];
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_pio_debounce_ctrl.sv
// Scoreboard bench for pio_debounce_ctrl: stimulus pushes expected read data,
// irq levels and tick spacings; monitors pop and compare as results appear.
module tb_pio_debounce_ctrl;
    import pio_ctrl_pkg::*;

    localparam int WIDTH = 18;

    logic             clk;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    pio_debounce_ctrl #(
        .WIDTH(WIDTH), .PERIOD_W(16), .DEFAULT_PERIOD(50000), .STABLE_COUNT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int arm_cyc = 0;

    logic rd_req = 1'b0, rd_vld = 1'b0, irq_req = 1'b0, tick_arm = 1'b0;

    logic [31:0] q_rd_exp[$];
    string       q_rd_name[$];
    logic        q_irq_exp[$];
    string       q_irq_name[$];
    int          q_tick_exp[$];
    string       q_tick_name[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_vld <= rd_req;
    end

    // Monitors: readdata one cycle after a read request, irq in the request
    // cycle, and the distance from an armed point to the next prescaler tick.
    always @(negedge clk) begin
        if (rd_vld && q_rd_exp.size() > 0)
            check(q_rd_name.pop_front(), readdata, q_rd_exp.pop_front());
        if (irq_req && q_irq_exp.size() > 0)
            check(q_irq_name.pop_front(), {31'd0, irq}, {31'd0, q_irq_exp.pop_front()});
        if (tick_arm) begin
            if (dut.w_tick && cyc > arm_cyc) begin
                check(q_tick_name.pop_front(), 32'(cyc - arm_cyc), 32'(q_tick_exp.pop_front()));
                tick_arm = 1'b0;
            end else if (cyc - arm_cyc > 200) begin
                check({q_tick_name.pop_front(), "_timeout"}, 32'(cyc - arm_cyc), 32'(q_tick_exp.pop_front()));
                tick_arm = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr_timed(input logic [1:0] a, input logic [31:0] d, input int gap, input string name);
        q_tick_exp.push_back(gap);
        q_tick_name.push_back(name);
        arm_cyc  = cyc;
        tick_arm = 1'b1;
        wr(a, d);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        q_rd_exp.push_back(exp);
        q_rd_name.push_back(name);
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic irq_chk(input logic exp, input string name);
        q_irq_exp.push_back(exp);
        q_irq_name.push_back(name);
        irq_req = 1'b1;
        @(posedge clk);
        #1;
        irq_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = '0; writedata = '0; in_port = '0;
        idle(3);
        reset = 1'b0;

        rd(ADDR_DATA,   32'h0,    "rst_data");
        rd(ADDR_MASK,   32'h0,    "rst_mask");
        rd(ADDR_PERIOD, 32'hC350, "rst_period");
        rd(ADDR_EDGE,   32'h0,    "rst_edge");
        irq_chk(1'b0, "rst_irq");

        // Commit of 0x00005: 2 sync + 4 ticks of 3 cycles + eval/commit
        in_port = 18'h00005;
        wr(ADDR_PERIOD, 32'd3);
        idle(14);
        rd(ADDR_DATA, 32'h5, "commit_data");
        rd(ADDR_EDGE, 32'h5, "commit_edge");
        irq_chk(1'b0, "commit_irq_masked");

        wr(ADDR_MASK, 32'h3FFFF);
        irq_chk(1'b1, "mask_irq_set");
        rd(ADDR_MASK, 32'h3FFFF, "mask_readback");
        wr(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE, 32'h4, "w1c_bit0");
        irq_chk(1'b1, "w1c_irq_hold");
        wr(ADDR_EDGE, 32'h4);
        irq_chk(1'b0, "w1c_irq_clear");
        rd(ADDR_EDGE, 32'h0, "w1c_all");

        // Two-tick glitch must never reach data_reg
        in_port = 18'h00007;
        idle(6);
        in_port = 18'h00005;
        idle(30);
        rd(ADDR_DATA, 32'h5, "glitch_data");
        rd(ADDR_EDGE, 32'h0, "glitch_edge");
        irq_chk(1'b0, "glitch_irq");

        // Prescaler clamp and forced reload
        wr_timed(ADDR_PERIOD, 32'd0, 3, "tick_clamp_first");
        wait (!tick_arm);
        q_tick_exp.push_back(3);
        q_tick_name.push_back("tick_clamp_repeat");
        arm_cyc  = cyc;
        tick_arm = 1'b1;
        wait (!tick_arm);
        @(posedge clk);
        #1;
        rd(ADDR_PERIOD, 32'h0, "period_zero");
        idle(1);
        wr_timed(ADDR_PERIOD, 32'd10, 10, "tick_reload");
        wait (!tick_arm);
        @(posedge clk);
        #1;
        rd(ADDR_PERIOD, 32'd10, "period_ten");

        // Commit of 5->4 lands on the same edge as a W1C of bit 0
        in_port = 18'h00004;
        wr(ADDR_PERIOD, 32'd3);
        idle(13);
        wr(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE, 32'h1, "collision_edge");
        rd(ADDR_DATA, 32'h4, "collision_data");
        irq_chk(1'b1, "collision_irq");

        // Reset while the pending 4->0 commit is in S_EVAL
        in_port = 18'h00000;
        wr(ADDR_PERIOD, 32'd3);
        idle(12);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        rd(ADDR_DATA,   32'h0,    "midrst_data");
        rd(ADDR_MASK,   32'h0,    "midrst_mask");
        rd(ADDR_PERIOD, 32'hC350, "midrst_period");
        rd(ADDR_EDGE,   32'h0,    "midrst_edge");
        irq_chk(1'b0, "midrst_irq");

        // First commit after reset takes its edges relative to zero
        in_port = 18'h20001;
        wr(ADDR_PERIOD, 32'd3);
        idle(14);
        rd(ADDR_DATA, 32'h20001, "postrst_data");
        rd(ADDR_EDGE, 32'h20001, "postrst_edge");

        idle(2);
        check("scoreboard_drained", 32'(q_rd_exp.size() + q_irq_exp.size() + q_tick_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_debounce_ctrl.md
Name: pio_debounce_ctrl

Overview:
Controller placed in front of the system's 18-bit switch/button input PIO. It synchronises and periodically samples the raw input port, and debounces the whole word. It records per-bit edges and raises a maskable interrupt. It exposes a 4-word Avalon-MM slave with fixed 1-cycle read latency, so the Nios II reads clean switch state and edge events instead of raw pins.

Parameters:
WIDTH, 18, input port width (1..32)
PERIOD_W, 16, width of sample-period register
DEFAULT_PERIOD, 50000, sample period in clk cycles after reset (1 ms at 50 MHz)
STABLE_COUNT, 4, consecutive identical samples required to commit (2..15)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
address  in  2  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  WIDTH  raw asynchronous switch/button inputs
irq  out  1  level interrupt, active-high

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset). Every register clears on the clk edge where reset=1.
- Reset values: readdata=0, irq=0, data_reg=0, cand=0, stab_cnt=0, edgecap=0, mask=0, period=DEFAULT_PERIOD, prescaler=0, sync stages=0, FSM=S_WAIT.
- Input synchroniser: 2-FF synchroniser on in_port; sync_q is the second stage.
- Prescaler:
  - eff_period = max(period, 3).
  - The counter runs 0..eff_period-1; tick=1 for one cycle when the count equals eff_period-1, then the count wraps to 0.
  - A period write forces the prescaler to 0 on the same edge.
- FSM:
  - S_WAIT: on tick, latch sample<=sync_q and go to S_EVAL.
  - S_EVAL, match case: if sample==cand and stab_cnt==STABLE_COUNT-2 and cand!=data_reg, go to S_COMMIT. Otherwise, if sample==cand, stab_cnt saturates-increments toward STABLE_COUNT-1.
  - S_EVAL, mismatch case: cand<=sample, stab_cnt<=0.
  - S_EVAL then returns to S_WAIT unless it went to S_COMMIT.
  - S_COMMIT: edgecap<=edgecap | (data_reg^cand); data_reg<=cand; stab_cnt<=STABLE_COUNT-1; go to S_WAIT.
  - Net effect: a value is committed after STABLE_COUNT consecutive equal ticks (the first tick loads cand). Glitches shorter than STABLE_COUNT ticks are never committed.
  - eff_period>=3 guarantees no tick arrives outside S_WAIT.
- Register map (unused upper bits read 0; writes ignore them):
  - 0 data: data_reg, read-only.
  - 1 mask: irq mask, read/write.
  - 2 period: PERIOD_W bits, read/write.
  - 3 edgecap: read; a write clears every bit where writedata=1 (W1C).
- Write: occurs when chipselect=1 and write_n=0.
- Read: readdata updates every cycle from the address-selected register, giving fixed 1-cycle latency. Read has no side effects.
- Edge capture collision: when S_COMMIT sets an edgecap bit in the same cycle a W1C clears it, the set wins.
- irq: registered, irq <= |(edgecap & mask) computed from next-state values, so irq is visible in the cycle after edgecap/mask change.
- Reset mid-operation: reset asserted during S_EVAL/S_COMMIT abandons the commit, and data_reg returns to 0. The first post-reset commit of a nonzero input sets edges relative to 0.

Decomposition:
- Shared package pio_ctrl_pkg holds:
  - address constants: ADDR_DATA=0, ADDR_MASK=1, ADDR_PERIOD=2, ADDR_EDGE=3
  - FSM state enum: S_WAIT, S_EVAL, S_COMMIT
  - MIN_PERIOD=3
- One natural sub-module: pio_sample_tick (prescaler with period load, forced reload and min clamp). Everything else lives in pio_debounce_ctrl.

Test Plan:
- Reset → read each address 0..3: expected 0x0, 0x0, 0xC350 (50000), 0x0; irq=0.
- Write period=3; set in_port=0x00005 and hold → data reads 0x00005 within 2+4×3+2 cycles of the change; edgecap=0x00005; irq=0 (mask=0).
- Write mask=0x3FFFF after the previous scenario → irq=1 the next cycle. Write 0x00001 to addr 3 → edgecap=0x00004, irq stays 1. Write 0x00004 → edgecap=0, irq=0 the next cycle.
- Glitch test (period=3, data=0x00005): pulse in_port to 0x00007 for 2 ticks (6 cycles), then back → data stays 0x00005, edgecap unchanged, no irq.
- Write period=0 → tick every 3 cycles (clamp). Write period=10 mid-count → the next tick occurs exactly 10 cycles after the write.
- Collision and reset: force a commit of bit 0 in the same cycle as a W1C of bit 0 → edgecap bit 0=1. Then assert reset for 1 cycle during S_EVAL → all registers return to reset values, period=50000.
